ex_mem_pipe: RTL and testbench
==============================

Name: ex_mem_pipe

Overview:
- Parametrised EX/MEM pipeline register for the MIPS core; successor to the plain three-field EX/MEM latch.
- Registers ALU result, destination register, write enable, load/store info (aluop, address, store data) and HI/LO write data.
- Adds stall hold, bubble insertion, flush, and a feedback path that keeps multi-cycle EX operation state (madd/msub) across stalls.
- Sits between the EX stage and the MEM stage; stall/flush come from the pipeline control block.

Parameters:
- DATA_W, 32, width of data, address and HI/LO buses
- REG_ADDR_W, 5, register-file address width
- ALUOP_W, 8, width of the aluop code carried to MEM
- CNT_W, 2, width of the multi-cycle EX step counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset (RstEnable = 1)
- stall_ex  in  1  EX stage stalled
- stall_mem  in  1  MEM stage stalled
- flush  in  1  exception flush; kill the entry
- ex_wdata  in  DATA_W  ALU result
- ex_addr  in  REG_ADDR_W  destination register
- ex_we  in  1  register write enable
- ex_aluop  in  ALUOP_W  operation code, for load/store decode in MEM
- ex_mem_addr  in  DATA_W  effective memory address
- ex_reg2  in  DATA_W  store data
- ex_cnt  in  CNT_W  current multi-cycle step
- ex_hilo_temp  in  2*DATA_W  partial multi-cycle product
- mem_wdata  out  DATA_W  registered ex_wdata
- mem_addr  out  REG_ADDR_W  registered ex_addr
- mem_we  out  1  registered ex_we
- mem_aluop  out  ALUOP_W  registered ex_aluop
- mem_mem_addr  out  DATA_W  registered ex_mem_addr
- mem_reg2  out  DATA_W  registered ex_reg2
- mem_valid  out  1  entry holds a real instruction
- cnt_o  out  CNT_W  step counter fed back to EX
- hilo_temp_o  out  2*DATA_W  partial product fed back to EX

Behaviour:
- Single clock domain. Outputs are registered only; no combinational input-to-output path. Latency is 1 cycle.
- Reset (rst=1 at the edge):
  - mem_addr = NOPRegAddr (0); mem_we = WriteDisable; mem_valid = 0.
  - All data, aluop (NOP code 0), cnt_o and hilo_temp_o = 0.
- Action at each edge, in priority order:
  1. rst: reset as above.
  2. flush: same values as reset. Clears cnt_o and hilo_temp_o, so a multi-cycle op is abandoned.
  3. stall_ex=1 and stall_mem=0 (bubble):
     - Pipeline fields take reset values; mem_valid = 0.
     - cnt_o <= ex_cnt; hilo_temp_o <= ex_hilo_temp (EX resumes the multi-cycle op next cycle).
  4. stall_ex=0 (advance):
     - All mem_* fields <= ex_* inputs; mem_valid = 1.
     - cnt_o = 0; hilo_temp_o = 0.
  5. Otherwise (stall_ex=1 and stall_mem=1, hold): all outputs keep their values.
- stall_ex=0 with stall_mem=1 is illegal: a later stage stalled implies earlier stages stalled. The design treats it as hold; the bench asserts it never occurs.
- A flush asserted together with any stall combination wins; the entry is cleared the same cycle.
- Reset mid multi-cycle op discards the partial product.

Optional Feature:
- Macro: EX_MEM_HILO_EN.
- Defined:
  - Adds inputs ex_hi, ex_lo (DATA_W) and ex_whilo (1).
  - Adds outputs mem_hi, mem_lo, mem_whilo, following the same reset/flush/bubble/advance/hold rules.
  - Bubble and flush force mem_whilo = 0.
- Undefined: these ports do not exist; HI/LO writes bypass this block.

Decomposition:
- Shared package/define file holds: RstEnable, WriteDisable, NOPRegAddr, ZeroWord, EXE_NOP_OP aluop code, and the default widths.
- No sub-module is needed.
- A small generic pipe_reg (data, load, clear) is natural if the team wants reuse across ID/EX and MEM/WB; the control priority stays in ex_mem_pipe.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_we=1, ex_wdata=0xDEADBEEF -> mem_we=0, mem_wdata=0, mem_valid=0, cnt_o=0.
- Advance: ex_wdata=0x12345678, ex_addr=5, ex_we=1, stalls 0 -> one edge later mem_wdata=0x12345678, mem_addr=5, mem_we=1, mem_valid=1.
- Bubble: stall_ex=1, stall_mem=0, ex_cnt=1, ex_hilo_temp=0x0000_0001_0000_0002 -> mem_we=0, mem_valid=0, cnt_o=1, hilo_temp_o=0x0000_0001_0000_0002.
- Hold: load 0xAAAA5555/addr 7, then stall_ex=stall_mem=1 for 3 cycles while inputs change -> outputs remain 0xAAAA5555/7/we=1.
- Flush priority: flush=1 with stall_ex=1, stall_mem=0, ex_cnt=2 -> all outputs 0, cnt_o=0.
- With EX_MEM_HILO_EN: ex_whilo=1, ex_hi=0x1, ex_lo=0x2 advance -> mem_whilo=1, mem_hi=1, mem_lo=2; next edge bubble -> mem_whilo=0.

Source files
------------

// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and control encoding for the EX/MEM pipeline register.
package ex_mem_pipe_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [7:0]  EXE_NOP_OP   = 8'h00;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_ALUOP_W    = 8;
  localparam int unsigned DEF_CNT_W      = 2;

  typedef enum logic [1:0] {
    PIPE_HOLD    = 2'd0,
    PIPE_ADVANCE = 2'd1,
    PIPE_BUBBLE  = 2'd2,
    PIPE_CLEAR   = 2'd3
  } pipe_act_e;

endpackage

// File: rtl/ex_mem_pipe_reg.sv
// Generic pipeline register: synchronous reset/clear to RST_VAL, load, else hold.
module ex_mem_pipe_reg
  import ex_mem_pipe_pkg::*;
#(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall hold, bubble, flush and multi-cycle EX feedback.
// Optional HI/LO write path enabled by defining EX_MEM_HILO_EN.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned ALUOP_W    = DEF_ALUOP_W,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [REG_ADDR_W-1:0] ex_addr,
  input  logic                  ex_we,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [CNT_W-1:0]      ex_cnt,
  input  logic [2*DATA_W-1:0]   ex_hilo_temp,
`ifdef EX_MEM_HILO_EN
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
`endif
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [REG_ADDR_W-1:0] mem_addr,
  output logic                  mem_we,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic                  mem_valid,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [2*DATA_W-1:0]   hilo_temp_o
);

`ifdef EX_MEM_HILO_EN
  localparam int unsigned PIPE_W = 5*DATA_W + REG_ADDR_W + ALUOP_W + 2;
  localparam logic [PIPE_W-1:0] PIPE_RST = {DATA_W'(ZeroWord), REG_ADDR_W'(NOPRegAddr),
    WriteDisable, ALUOP_W'(EXE_NOP_OP), DATA_W'(ZeroWord), DATA_W'(ZeroWord),
    DATA_W'(ZeroWord), DATA_W'(ZeroWord), WriteDisable};
`else
  localparam int unsigned PIPE_W = 3*DATA_W + REG_ADDR_W + ALUOP_W + 1;
  localparam logic [PIPE_W-1:0] PIPE_RST = {DATA_W'(ZeroWord), REG_ADDR_W'(NOPRegAddr),
    WriteDisable, ALUOP_W'(EXE_NOP_OP), DATA_W'(ZeroWord), DATA_W'(ZeroWord)};
`endif
  localparam int unsigned FB_W = CNT_W + 2*DATA_W;

  pipe_act_e         act;
  logic [PIPE_W-1:0] pipe_d;
  logic [PIPE_W-1:0] pipe_q;
  logic [FB_W-1:0]   fb_q;
  logic              pipe_clr;
  logic              pipe_ld;
  logic              fb_clr;
  logic              fb_ld;

  // stall_ex=0 with stall_mem=1 cannot happen legally; it falls through to hold.
  always_comb begin
    act = PIPE_HOLD;
    if (flush) begin
      act = PIPE_CLEAR;
    end else if (stall_ex && !stall_mem) begin
      act = PIPE_BUBBLE;
    end else if (!stall_ex && !stall_mem) begin
      act = PIPE_ADVANCE;
    end
  end

  // Feedback state is loaded only by a bubble, so an advance or flush retires it.
  assign pipe_clr = (act == PIPE_CLEAR) || (act == PIPE_BUBBLE);
  assign pipe_ld  = (act == PIPE_ADVANCE);
  assign fb_clr   = (act == PIPE_CLEAR) || (act == PIPE_ADVANCE);
  assign fb_ld    = (act == PIPE_BUBBLE);

`ifdef EX_MEM_HILO_EN
  assign pipe_d = {ex_wdata, ex_addr, ex_we, ex_aluop, ex_mem_addr, ex_reg2,
                   ex_hi, ex_lo, ex_whilo};
  assign {mem_wdata, mem_addr, mem_we, mem_aluop, mem_mem_addr, mem_reg2,
          mem_hi, mem_lo, mem_whilo} = pipe_q;
`else
  assign pipe_d = {ex_wdata, ex_addr, ex_we, ex_aluop, ex_mem_addr, ex_reg2};
  assign {mem_wdata, mem_addr, mem_we, mem_aluop, mem_mem_addr, mem_reg2} = pipe_q;
`endif

  assign {cnt_o, hilo_temp_o} = fb_q;

  ex_mem_pipe_reg #(.W(PIPE_W), .RST_VAL(PIPE_RST)) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .clear (pipe_clr),
    .load  (pipe_ld),
    .d     (pipe_d),
    .q     (pipe_q)
  );

  ex_mem_pipe_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk   (clk),
    .rst   (rst),
    .clear (pipe_clr),
    .load  (pipe_ld),
    .d     (1'b1),
    .q     (mem_valid)
  );

  ex_mem_pipe_reg #(.W(FB_W), .RST_VAL('0)) u_fb (
    .clk   (clk),
    .rst   (rst),
    .clear (fb_clr),
    .load  (fb_ld),
    .d     ({ex_cnt, ex_hilo_temp}),
    .q     (fb_q)
  );

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed plan steps then random stimulus
// against a rule-level reference model. Define EX_MEM_HILO_EN to cover HI/LO.
module tb_ex_mem_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 8;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst, stall_ex, stall_mem, flush;
  logic [DW-1:0] ex_wdata, ex_mem_addr, ex_reg2;
  logic [AW-1:0] ex_addr;
  logic          ex_we;
  logic [OW-1:0] ex_aluop;
  logic [CW-1:0] ex_cnt;
  logic [2*DW-1:0] ex_hilo_temp;
  logic [DW-1:0] mem_wdata, mem_mem_addr, mem_reg2;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_valid;
  logic [OW-1:0] mem_aluop;
  logic [CW-1:0] cnt_o;
  logic [2*DW-1:0] hilo_temp_o;
  logic [DW-1:0] ex_hi, ex_lo, mem_hi, mem_lo;
  logic          ex_whilo, mem_whilo;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct packed {
    logic [DW-1:0]   wdata;
    logic [AW-1:0]   addr;
    logic            we;
    logic [OW-1:0]   aluop;
    logic [DW-1:0]   maddr;
    logic [DW-1:0]   reg2;
    logic            valid;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] hilo;
    logic [DW-1:0]   hi;
    logic [DW-1:0]   lo;
    logic            whilo;
  } exp_t;

  exp_t m;

  always #5 clk = ~clk;

  ex_mem_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush        (flush),
    .ex_wdata     (ex_wdata),
    .ex_addr      (ex_addr),
    .ex_we        (ex_we),
    .ex_aluop     (ex_aluop),
    .ex_mem_addr  (ex_mem_addr),
    .ex_reg2      (ex_reg2),
    .ex_cnt       (ex_cnt),
    .ex_hilo_temp (ex_hilo_temp),
`ifdef EX_MEM_HILO_EN
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .ex_whilo     (ex_whilo),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_whilo    (mem_whilo),
`endif
    .mem_wdata    (mem_wdata),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .mem_valid    (mem_valid),
    .cnt_o        (cnt_o),
    .hilo_temp_o  (hilo_temp_o)
  );

`ifndef EX_MEM_HILO_EN
  assign mem_hi    = '0;
  assign mem_lo    = '0;
  assign mem_whilo = 1'b0;
`endif

  // Rule-level model: reset/flush clear all, bubble parks EX state, advance copies.
  function automatic exp_t model_step(input exp_t cur);
    exp_t n;
    n = cur;
    if (rst || flush) begin
      n = '0;
    end else if (stall_ex && !stall_mem) begin
      n      = '0;
      n.cnt  = ex_cnt;
      n.hilo = ex_hilo_temp;
    end else if (!stall_ex) begin
      n       = '0;
      n.wdata = ex_wdata;
      n.addr  = ex_addr;
      n.we    = ex_we;
      n.aluop = ex_aluop;
      n.maddr = ex_mem_addr;
      n.reg2  = ex_reg2;
      n.valid = 1'b1;
      n.hi    = ex_hi;
      n.lo    = ex_lo;
      n.whilo = ex_whilo;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wdata"}, 64'(mem_wdata), 64'(m.wdata));
    chk({tag, ".addr"},  64'(mem_addr),  64'(m.addr));
    chk({tag, ".we"},    64'(mem_we),    64'(m.we));
    chk({tag, ".aluop"}, 64'(mem_aluop), 64'(m.aluop));
    chk({tag, ".maddr"}, 64'(mem_mem_addr), 64'(m.maddr));
    chk({tag, ".reg2"},  64'(mem_reg2),  64'(m.reg2));
    chk({tag, ".valid"}, 64'(mem_valid), 64'(m.valid));
    chk({tag, ".cnt"},   64'(cnt_o),     64'(m.cnt));
    chk({tag, ".hilo"},  hilo_temp_o,    m.hilo);
`ifdef EX_MEM_HILO_EN
    chk({tag, ".hi"},    64'(mem_hi),    64'(m.hi));
    chk({tag, ".lo"},    64'(mem_lo),    64'(m.lo));
    chk({tag, ".whilo"}, 64'(mem_whilo), 64'(m.whilo));
`endif
  endtask

  task automatic tick();
    assert (!(stall_mem && !stall_ex)) else begin
      $display("FAIL illegal_stall observed=stall_ex0_stall_mem1 expected=never");
      $fatal(1);
    end
    @(posedge clk);
    m = model_step(m);
    #1;
  endtask

  task automatic rand_data();
    ex_wdata     = $urandom;
    ex_addr      = AW'($urandom);
    ex_we        = 1'($urandom);
    ex_aluop     = OW'($urandom);
    ex_mem_addr  = $urandom;
    ex_reg2      = $urandom;
    ex_cnt       = CW'($urandom);
    ex_hilo_temp = {$urandom, $urandom};
    ex_hi        = $urandom;
    ex_lo        = $urandom;
    ex_whilo     = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    m = '0;
    rand_data();
    rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; stall_mem = 1'b0;
    ex_we = 1'b1; ex_wdata = 32'hDEAD_BEEF;
    tick();
    tick();
    check_all("reset");
    chk("reset_we",    64'(mem_we),    64'h0);
    chk("reset_wdata", 64'(mem_wdata), 64'h0);
    chk("reset_valid", 64'(mem_valid), 64'h0);
    chk("reset_cnt",   64'(cnt_o),     64'h0);

    rst = 1'b0;
    ex_wdata = 32'h1234_5678; ex_addr = 5'd5; ex_we = 1'b1;
    tick();
    check_all("advance");
    chk("adv_wdata", 64'(mem_wdata), 64'h1234_5678);
    chk("adv_addr",  64'(mem_addr),  64'd5);
    chk("adv_we",    64'(mem_we),    64'h1);
    chk("adv_valid", 64'(mem_valid), 64'h1);

    stall_ex = 1'b1; ex_cnt = 2'd1; ex_hilo_temp = 64'h0000_0001_0000_0002;
    tick();
    check_all("bubble");
    chk("bub_we",    64'(mem_we),    64'h0);
    chk("bub_valid", 64'(mem_valid), 64'h0);
    chk("bub_cnt",   64'(cnt_o),     64'd1);
    chk("bub_hilo",  hilo_temp_o,    64'h0000_0001_0000_0002);

    stall_ex = 1'b0; ex_wdata = 32'hAAAA_5555; ex_addr = 5'd7; ex_we = 1'b1;
    tick();
    stall_ex = 1'b1; stall_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick();
      check_all("hold");
      chk("hold_wdata", 64'(mem_wdata), 64'hAAAA_5555);
      chk("hold_addr",  64'(mem_addr),  64'd7);
      chk("hold_we",    64'(mem_we),    64'h1);
    end

    stall_mem = 1'b0; ex_cnt = 2'd3; ex_hilo_temp = 64'h1111_2222_3333_4444;
    tick();
    flush = 1'b1; ex_cnt = 2'd2;
    tick();
    check_all("flush");
    chk("flush_cnt",  64'(cnt_o),     64'h0);
    chk("flush_hilo", hilo_temp_o,    64'h0);
    chk("flush_we",   64'(mem_we),    64'h0);
    flush = 1'b0;

`ifdef EX_MEM_HILO_EN
    stall_ex = 1'b0; ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
    tick();
    chk("hilo_adv_whilo", 64'(mem_whilo), 64'h1);
    chk("hilo_adv_hi",    64'(mem_hi),    64'h1);
    chk("hilo_adv_lo",    64'(mem_lo),    64'h2);
    stall_ex = 1'b1;
    tick();
    chk("hilo_bub_whilo", 64'(mem_whilo), 64'h0);
`endif

    stall_ex = 1'b1; stall_mem = 1'b0; ex_cnt = 2'd2; ex_hilo_temp = 64'hFFFF_0000_FFFF_0000;
    tick();
    stall_mem = 1'b1; rst = 1'b1;
    tick();
    check_all("reset_mid_op");
    chk("rst_mid_hilo", hilo_temp_o, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      rand_data();
      r = $urandom_range(0, 9);
      stall_ex  = (r >= 5);
      stall_mem = (r >= 8);
      flush     = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      tick();
      check_all("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
